// File: rtl/systolic_mm_engine_if.sv
// Stream and readback signals of the systolic matrix-multiply engine.
// Signal prefixes are from the engine's point of view: i_ flows into it, o_ flows out of it.
`timescale 1ns/1ps
interface systolic_mm_engine_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int ROWS    = 8,
  parameter int COLS    = 8
);
  localparam int CRW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                              i_start;
  logic                              i_accum;
  logic [15:0]                       i_k_len;
  logic                              i_in_valid;
  logic                              o_in_ready;
  logic [ROWS-1:0][BITS_AB-1:0]      i_a_in;
  logic [COLS-1:0][BITS_AB-1:0]      i_b_in;
  logic [CRW-1:0]                    i_c_row;
  logic [COLS-1:0][BITS_C-1:0]       o_c_out;
  logic                              o_busy;
  logic                              o_done;

  modport master (
    output i_start, i_accum, i_k_len, i_in_valid, i_a_in, i_b_in, i_c_row,
    input  o_in_ready, o_c_out, o_busy, o_done
  );

  modport slave (
    input  i_start, i_accum, i_k_len, i_in_valid, i_a_in, i_b_in, i_c_row,
    output o_in_ready, o_c_out, o_busy, o_done
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWSxCOLS systolic multiply engine computing C += A*B with
// internal operand skew, its own feed/drain control and optional saturation.
`timescale 1ns/1ps
module systolic_mm_engine #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int SAT     = 1
) (
  input logic                clk,
  input logic                rst,
  systolic_mm_engine_if.slave bus
);
  localparam int CRW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW        = 2 * BITS_AB;
  localparam int SW        = ((BITS_C > PW) ? BITS_C : PW) + 1;
  localparam int DRAIN_LEN = ROWS + COLS - 2;
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_LEN - 1);
  localparam logic [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_k_len, r_beat_cnt, r_drain_cnt;
  logic        w_start_go, w_beat, w_step, w_feed;

  logic [BITS_AB-1:0] w_a_sk [ROWS];
  logic [BITS_AB-1:0] w_b_sk [COLS];
  logic [BITS_AB-1:0] w_a_pe [ROWS][COLS];
  logic [BITS_AB-1:0] w_b_pe [ROWS][COLS];
  logic [BITS_C-1:0]  w_acc  [ROWS][COLS];

  assign w_start_go = (r_state == S_IDLE) && bus.i_start;
  assign w_feed     = (r_state == S_FEED);
  assign w_beat     = w_feed && bus.i_in_valid;
  assign w_step     = w_beat || (r_state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    bus.o_in_ready = 1'b0;
    bus.o_busy     = (r_state != S_IDLE);
    bus.o_done     = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_next = (bus.i_k_len == 16'd0) ? S_DONE : S_FEED;
      S_FEED: begin
        bus.o_in_ready = 1'b1;
        if (w_beat && (r_beat_cnt == r_k_len - 16'd1))
          w_state_next = (DRAIN_LEN == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_next = S_DONE;
      S_DONE: begin
        bus.o_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else if (w_start_go) begin
      r_k_len     <= bus.i_k_len;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_beat)               r_beat_cnt  <= r_beat_cnt + 16'd1;
      if (r_state == S_DRAIN)   r_drain_cnt <= r_drain_cnt + 16'd1;
    end
  end

  // Row i of A is delayed i steps and column j of B j steps; zeros are injected while draining.
  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_askew
      logic [BITS_AB-1:0] w_src;
      assign w_src = w_feed ? bus.i_a_in[gi] : '0;
      if (gi == 0) begin : g_direct
        assign w_a_sk[gi] = w_src;
      end else begin : g_delay
        logic [BITS_AB-1:0] r_sh [gi];
        always_ff @(posedge clk) begin
          if (rst || w_start_go) begin
            for (int n = 0; n < gi; n++) r_sh[n] <= '0;
          end else if (w_step) begin
            r_sh[0] <= w_src;
            for (int n = 1; n < gi; n++) r_sh[n] <= r_sh[n-1];
          end
        end
        assign w_a_sk[gi] = r_sh[gi-1];
      end
    end

    for (gi = 0; gi < COLS; gi++) begin : g_bskew
      logic [BITS_AB-1:0] w_src;
      assign w_src = w_feed ? bus.i_b_in[gi] : '0;
      if (gi == 0) begin : g_direct
        assign w_b_sk[gi] = w_src;
      end else begin : g_delay
        logic [BITS_AB-1:0] r_sh [gi];
        always_ff @(posedge clk) begin
          if (rst || w_start_go) begin
            for (int n = 0; n < gi; n++) r_sh[n] <= '0;
          end else if (w_step) begin
            r_sh[0] <= w_src;
            for (int n = 1; n < gi; n++) r_sh[n] <= r_sh[n-1];
          end
        end
        assign w_b_sk[gi] = r_sh[gi-1];
      end
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_pe
        logic [BITS_AB-1:0]   w_ax, w_bx, r_a, r_b;
        logic [BITS_C-1:0]    r_c, w_c_next;
        logic signed [PW-1:0] w_prod;
        logic [SW-1:0]        w_sum;
        logic                 w_ovf;

        if (gj == 0) begin : g_aleft
          assign w_ax = w_a_sk[gi];
        end else begin : g_ain
          assign w_ax = w_a_pe[gi][gj-1];
        end
        if (gi == 0) begin : g_btop
          assign w_bx = w_b_sk[gj];
        end else begin : g_bin
          assign w_bx = w_b_pe[gi-1][gj];
        end

        assign w_prod = $signed(w_ax) * $signed(w_bx);
        assign w_sum  = {{(SW-BITS_C){r_c[BITS_C-1]}}, r_c} + {{(SW-PW){w_prod[PW-1]}}, w_prod};
        // Overflow whenever the bits above the result sign are not a pure sign extension.
        assign w_ovf  = !((&w_sum[SW-1:BITS_C-1]) || !(|w_sum[SW-1:BITS_C-1]));

        always_comb begin
          w_c_next = w_sum[BITS_C-1:0];
          if ((SAT != 0) && w_ovf) w_c_next = w_sum[SW-1] ? C_MIN : C_MAX;
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
          end else if (w_start_go) begin
            r_a <= '0;
            r_b <= '0;
            if (!bus.i_accum) r_c <= '0;
          end else if (w_step) begin
            r_a <= w_ax;
            r_b <= w_bx;
            r_c <= w_c_next;
          end
        end

        assign w_a_pe[gi][gj] = r_a;
        assign w_b_pe[gi][gj] = r_b;
        assign w_acc[gi][gj]  = r_c;
      end
    end
  endgenerate

  logic [CRW:0] w_row_ext;
  assign w_row_ext = {1'b0, bus.i_c_row};

  always_comb begin
    bus.o_c_out = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (w_row_ext == r[CRW:0]) begin
        for (int c = 0; c < COLS; c++) bus.o_c_out[c] = w_acc[r][c];
      end
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench: table of matrix jobs plus hand-written reset, k_len=0 and busy-start sequences.
// A saturating and a wrapping engine run the same stimulus side by side.
`timescale 1ns/1ps
module tb_systolic_mm_engine;
  localparam int BA = 8;
  localparam int BC = 16;
  localparam int R  = 8;
  localparam int C  = 8;
  localparam int AK_ID = 0, AK_ZERO = 1, AK_127 = 2;
  localparam int BK_RAMP = 0, BK_127 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_mm_engine_if #(.BITS_AB(BA), .BITS_C(BC), .ROWS(R), .COLS(C)) bus_s ();
  systolic_mm_engine_if #(.BITS_AB(BA), .BITS_C(BC), .ROWS(R), .COLS(C)) bus_w ();

  assign bus_w.i_start    = bus_s.i_start;
  assign bus_w.i_accum    = bus_s.i_accum;
  assign bus_w.i_k_len    = bus_s.i_k_len;
  assign bus_w.i_in_valid = bus_s.i_in_valid;
  assign bus_w.i_a_in     = bus_s.i_a_in;
  assign bus_w.i_b_in     = bus_s.i_b_in;
  assign bus_w.i_c_row    = bus_s.i_c_row;

  systolic_mm_engine #(.BITS_AB(BA), .BITS_C(BC), .ROWS(R), .COLS(C), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .bus(bus_s)
  );
  systolic_mm_engine #(.BITS_AB(BA), .BITS_C(BC), .ROWS(R), .COLS(C), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .bus(bus_w)
  );

  typedef struct {
    string name;
    int    ak;
    int    bk;
    int    k;
    bit    acc;
    bit    stall;
    bit    pulse;
    int    s_scale;
    int    s_const;
    int    w_scale;
    int    w_const;
  } job_t;

  job_t jobs [5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] a_val(input int ak, input int i, input int k);
    case (ak)
      AK_ID:   a_val = (i == k) ? 8'd1 : 8'd0;
      AK_127:  a_val = 8'd127;
      default: a_val = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] b_val(input int bk, input int k, input int j);
    int v;
    v = (bk == BK_RAMP) ? (k * 8 + j) : 127;
    b_val = v[7:0];
  endfunction

  task automatic drive_beat(input int ak, input int bk, input int beat);
    for (int i = 0; i < R; i++) bus_s.i_a_in[i] = a_val(ak, i, beat);
    for (int j = 0; j < C; j++) bus_s.i_b_in[j] = b_val(bk, beat, j);
  endtask

  // Expected C[r][c] = scale*(8r+c) + const, for both engines (wrap checked when chk_w=1).
  task automatic check_c(input string tag, input int ss, input int sc,
                         input bit chk_w, input int ws, input int wc);
    for (int r = 0; r < R; r++) begin
      bus_s.i_c_row = r[2:0];
      #1;
      for (int c = 0; c < C; c++) begin
        chk($sformatf("%s sat C[%0d][%0d]", tag, r, c),
            int'($signed(bus_s.o_c_out[c])), ss * (r * 8 + c) + sc);
        if (chk_w)
          chk($sformatf("%s wrap C[%0d][%0d]", tag, r, c),
              int'($signed(bus_w.o_c_out[c])), ws * (r * 8 + c) + wc);
      end
    end
  endtask

  task automatic run_job(input job_t jb, output int first_c, output int last_c,
                         output int done_c, output int drain_bad, output int beats);
    int  guard;
    bit  v;
    @(negedge clk);
    bus_s.i_start = 1'b1;
    bus_s.i_accum = jb.acc;
    bus_s.i_k_len = 16'(jb.k);
    @(negedge clk);
    bus_s.i_start = 1'b0;
    beats = 0; first_c = -1; last_c = -1; guard = 0;
    while (beats < jb.k && guard < 1000) begin
      v = jb.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus_s.i_in_valid = v;
      drive_beat(jb.ak, jb.bk, beats);
      if (v && bus_s.o_in_ready) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    bus_s.i_in_valid = 1'b0;
    drive_beat(AK_ZERO, BK_127, 0);
    for (int j = 0; j < C; j++) bus_s.i_b_in[j] = '0;
    done_c = -1; drain_bad = 0;
    for (int n = 0; n < 300; n++) begin
      if (bus_s.o_done) begin
        done_c = cyc;
        break;
      end
      if (bus_s.o_in_ready || !bus_s.o_busy || bus_w.o_in_ready) drain_bad++;
      if (jb.pulse && n == 1) begin
        bus_s.i_start = 1'b1;
        bus_s.i_accum = 1'b0;
        bus_s.i_k_len = 16'd0;
      end else begin
        bus_s.i_start = 1'b0;
      end
      @(negedge clk);
    end
    bus_s.i_start = 1'b0;
    chk({jb.name, " wrap_done"}, int'(bus_w.o_done), 1);
    @(negedge clk);
    chk({jb.name, " busy_after_done"}, int'(bus_s.o_busy), 0);
  endtask

  task automatic do_job(input job_t jb);
    int first_c, last_c, done_c, drain_bad, beats;
    run_job(jb, first_c, last_c, done_c, drain_bad, beats);
    chk({jb.name, " beats"}, beats, jb.k);
    chk({jb.name, " done_seen"}, int'(done_c >= 0), 1);
    chk({jb.name, " in_ready_low_drain"}, drain_bad, 0);
    chk({jb.name, " done_latency"}, done_c - first_c + 1, (last_c - first_c + 1) + R + C - 1);
    if (!jb.stall) chk({jb.name, " feed_span"}, last_c - first_c + 1, jb.k);
    $display("job %s: beats=%0d feed_cycles=%0d first_beat_to_done=%0d",
             jb.name, beats, last_c - first_c + 1, done_c - first_c + 1);
    check_c(jb.name, jb.s_scale, jb.s_const, 1'b1, jb.w_scale, jb.w_const);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    jobs[0] = '{"ident",       AK_ID,   BK_RAMP, 8, 1'b0, 1'b0, 1'b0, 1, 0,     1, 0};
    jobs[1] = '{"ident_stall", AK_ID,   BK_RAMP, 8, 1'b0, 1'b1, 1'b1, 1, 0,     1, 0};
    jobs[2] = '{"accum",       AK_ID,   BK_RAMP, 8, 1'b1, 1'b0, 1'b0, 2, 0,     2, 0};
    jobs[3] = '{"zero_a",      AK_ZERO, BK_RAMP, 8, 1'b0, 1'b0, 1'b0, 0, 0,     0, 0};
    jobs[4] = '{"sat_127",     AK_127,  BK_127,  4, 1'b0, 1'b0, 1'b0, 0, 32767, 0, -1020};

    bus_s.i_start = 1'b0; bus_s.i_accum = 1'b0; bus_s.i_k_len = '0;
    bus_s.i_in_valid = 1'b0; bus_s.i_c_row = '0;
    bus_s.i_a_in = '0; bus_s.i_b_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(bus_s.o_busy), 0);
    chk("reset in_ready", int'(bus_s.o_in_ready), 0);
    chk("reset done", int'(bus_s.o_done), 0);
    check_c("reset", 0, 0, 1'b1, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (jobs[t]) do_job(jobs[t]);

    // Reset three beats into an accumulate job: everything must clear at once.
    @(negedge clk);
    bus_s.i_start = 1'b1; bus_s.i_accum = 1'b1; bus_s.i_k_len = 16'd8;
    @(negedge clk);
    bus_s.i_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus_s.i_in_valid = 1'b1;
      drive_beat(AK_ID, BK_RAMP, b);
      @(negedge clk);
    end
    chk("pre_rst busy", int'(bus_s.o_busy), 1);
    rst = 1'b1;
    bus_s.i_in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst busy", int'(bus_s.o_busy), 0);
    chk("mid_rst in_ready", int'(bus_s.o_in_ready), 0);
    chk("mid_rst done", int'(bus_s.o_done), 0);
    check_c("mid_rst", 0, 0, 1'b1, 0, 0);
    $display("seq mid_job_reset: reset after 3 beats");
    rst = 1'b0;
    do_job(jobs[0]);

    // k_len=0: one busy cycle carrying done, accumulators cleared.
    @(negedge clk);
    bus_s.i_start = 1'b1; bus_s.i_accum = 1'b0; bus_s.i_k_len = 16'd0;
    @(negedge clk);
    bus_s.i_start = 1'b0;
    chk("kzero busy", int'(bus_s.o_busy), 1);
    chk("kzero done", int'(bus_s.o_done), 1);
    chk("kzero in_ready", int'(bus_s.o_in_ready), 0);
    @(negedge clk);
    chk("kzero busy_after", int'(bus_s.o_busy), 0);
    chk("kzero done_after", int'(bus_s.o_done), 0);
    check_c("kzero", 0, 0, 1'b1, 0, 0);
    $display("seq k_len_zero: done one cycle after start");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
